rf_wb_arbiter: RTL and testbench

Arbitrates the register file's single write port between the in-order pipeline writeback (requester A) and the multi-cycle M-extension mul/div unit (requester B).
Keeps a 32-entry pending-write scoreboard for in-flight mul/div destinations, which decode uses to detect hazards.
Raises a pipeline stall request when B is starved.
Sits between the WB stage / MDU and reg_file; drives reg_file IN/ADDRW/WRITE from registered outputs.

---
 rtl/rf_wb_arbiter.sv | 154 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB (A, fixed priority) vs MDU (B),
// pending-write scoreboard and B-starvation stall. Optional bypass: RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_OUT      = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_a_valid,
  input  logic [4:0]      i_a_addr,
  input  logic [XLEN-1:0] i_a_data,
  input  logic            i_b_valid,
  input  logic [4:0]      i_b_addr,
  input  logic [XLEN-1:0] i_b_data,
  output logic            o_b_ready,
  input  logic            i_issue_valid,
  input  logic [4:0]      i_issue_rd,
  output logic            o_issue_ready,
  input  logic [4:0]      i_addr1,
  input  logic [4:0]      i_addr2,
  output logic            o_haz1,
  output logic            o_haz2,
  output logic            o_stall_req,
  output logic [XLEN-1:0] o_rf_in,
  output logic [4:0]      o_rf_addrw,
  output logic            o_rf_write
`ifdef RF_WB_BYPASS_EN
  ,
  output logic            o_byp1_hit,
  output logic            o_byp2_hit,
  output logic [XLEN-1:0] o_byp1_data,
  output logic [XLEN-1:0] o_byp2_data
`endif
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
  localparam logic [3:0]    SLIM    = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STALL} st_t;

  logic            w_a_real, w_b_acc, w_blocked, w_issue_fire;
  logic [31:0]     r_pend;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rf_in;
  logic [4:0]      r_rf_addrw;
  logic            r_rf_write;
  st_t             r_st, w_st_nxt;
  logic [3:0]      r_sc, w_sc_nxt;

  assign w_a_real      = i_a_valid && (i_a_addr != 5'd0);
  assign w_b_acc       = i_b_valid && !w_a_real;
  assign w_blocked     = i_b_valid && !w_b_acc;
  assign w_issue_fire  = i_issue_valid && o_issue_ready;

  assign o_b_ready     = w_b_acc;
  assign o_issue_ready = (r_cnt < MAX_CNT) && !r_pend[i_issue_rd];
  // bit 0 is never set, so x0 never reports a hazard
  assign o_haz1        = r_pend[i_addr1];
  assign o_haz2        = r_pend[i_addr2];
  assign o_stall_req   = (r_st == S_STALL);
  assign o_rf_in       = r_rf_in;
  assign o_rf_addrw    = r_rf_addrw;
  assign o_rf_write    = r_rf_write;

`ifdef RF_WB_BYPASS_EN
  assign o_byp1_hit  = r_rf_write && (r_rf_addrw == i_addr1) && (i_addr1 != 5'd0);
  assign o_byp2_hit  = r_rf_write && (r_rf_addrw == i_addr2) && (i_addr2 != 5'd0);
  assign o_byp1_data = r_rf_in;
  assign o_byp2_data = r_rf_in;
`endif

  // Write-port commit; x0 writes and idle cycles hold data/addr
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rf_in    <= '0;
      r_rf_addrw <= '0;
      r_rf_write <= 1'b0;
    end else if (w_a_real) begin
      r_rf_in    <= i_a_data;
      r_rf_addrw <= i_a_addr;
      r_rf_write <= 1'b1;
    end else if (w_b_acc && (i_b_addr != 5'd0)) begin
      r_rf_in    <= i_b_data;
      r_rf_addrw <= i_b_addr;
      r_rf_write <= 1'b1;
    end else begin
      r_rf_write <= 1'b0;
    end
  end

  // Scoreboard and outstanding count; set/clear of one rd can't coincide
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_b_acc)
        r_pend[i_b_addr] <= 1'b0;
      if (w_issue_fire && (i_issue_rd != 5'd0))
        r_pend[i_issue_rd] <= 1'b1;
      if (w_issue_fire && !w_b_acc)
        r_cnt <= r_cnt + 1'b1;
      else if (!w_issue_fire && w_b_acc && (r_cnt != '0))
        r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st <= S_IDLE;
      r_sc <= '0;
    end else begin
      r_st <= w_st_nxt;
      r_sc <= w_sc_nxt;
    end
  end

  always_comb begin
    w_st_nxt = r_st;
    w_sc_nxt = r_sc;
    case (r_st)
      S_IDLE: begin
        if (w_blocked) begin
          w_sc_nxt = 4'd1;
          w_st_nxt = (SLIM <= 4'd1) ? S_STALL : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_blocked) begin
          w_sc_nxt = '0;
          w_st_nxt = S_IDLE;
        end else begin
          w_sc_nxt = r_sc + 4'd1;
          if ((r_sc + 4'd1) >= SLIM)
            w_st_nxt = S_STALL;
        end
      end
      S_STALL: begin
        // A may still win here; only a B accept releases the stall
        if (w_b_acc) begin
          w_sc_nxt = '0;
          w_st_nxt = S_IDLE;
        end
      end
      default: begin
        w_sc_nxt = '0;
        w_st_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios then random traffic against a
// behavioural model (scoreboard array, MDU queue, consecutive-blocked counter).
module tb_rf_wb_arbiter;
  localparam int XLEN = 32;
  localparam int SL   = 4;
  localparam int MO   = 2;

  logic            clk, rst_n;
  logic            a_valid, b_valid, issue_valid;
  logic [4:0]      a_addr, b_addr, issue_rd, addr1, addr2;
  logic [XLEN-1:0] a_data, b_data;
  logic            b_ready, issue_ready, haz1, haz2, stall_req, rf_write;
  logic [XLEN-1:0] rf_in;
  logic [4:0]      rf_addrw;
`ifdef RF_WB_BYPASS_EN
  logic            byp1_hit, byp2_hit;
  logic [XLEN-1:0] byp1_data, byp2_data;
`endif

  rf_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(SL), .MAX_OUT(MO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(a_valid), .i_a_addr(a_addr), .i_a_data(a_data),
    .i_b_valid(b_valid), .i_b_addr(b_addr), .i_b_data(b_data), .o_b_ready(b_ready),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd), .o_issue_ready(issue_ready),
    .i_addr1(addr1), .i_addr2(addr2), .o_haz1(haz1), .o_haz2(haz2),
    .o_stall_req(stall_req), .o_rf_in(rf_in), .o_rf_addrw(rf_addrw), .o_rf_write(rf_write)
`ifdef RF_WB_BYPASS_EN
    , .o_byp1_hit(byp1_hit), .o_byp2_hit(byp2_hit),
    .o_byp1_data(byp1_data), .o_byp2_data(byp2_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  bit   [31:0]     m_pend;
  int              m_cnt;
  bit              m_write, m_stall;
  logic [XLEN-1:0] m_in;
  logic [4:0]      m_addrw;
  int              m_starve;
  logic [4:0]      mq[$];

  task automatic model_reset();
    m_pend = '0; m_cnt = 0; m_write = 0; m_stall = 0;
    m_in = '0; m_addrw = '0; m_starve = 0;
    mq.delete();
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registers
  task automatic cyc(input bit av, input logic [4:0] aa, input logic [XLEN-1:0] ad,
                     input bit bv, input logic [4:0] ba, input logic [XLEN-1:0] bd,
                     input bit iv, input logic [4:0] ird,
                     input logic [4:0] a1, input logic [4:0] a2);
    bit a_real, bacc, irdy, fire;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    issue_valid = iv; issue_rd = ird; addr1 = a1; addr2 = a2;
    @(negedge clk);
    a_real = av && (aa != 0);
    bacc   = bv && !a_real;
    irdy   = (m_cnt < MO) && !m_pend[ird];
    fire   = iv && irdy;
    chk("b_ready", b_ready, bacc);
    chk("issue_ready", issue_ready, irdy);
    chk("haz1", haz1, m_pend[a1]);
    chk("haz2", haz2, m_pend[a2]);
`ifdef RF_WB_BYPASS_EN
    chk("byp1_hit", byp1_hit, m_write && m_addrw == a1 && a1 != 0);
    chk("byp2_hit", byp2_hit, m_write && m_addrw == a2 && a2 != 0);
    if (m_write) chk("byp1_data", byp1_data, m_in);
`endif
    @(posedge clk);
    if (a_real) begin
      m_write = 1; m_in = ad; m_addrw = aa;
    end else if (bacc && ba != 0) begin
      m_write = 1; m_in = bd; m_addrw = ba;
    end else m_write = 0;
    if (bacc) begin
      m_pend[ba] = 0;
      if (mq.size() > 0) void'(mq.pop_front());
    end
    if (fire) begin
      if (ird != 0) m_pend[ird] = 1;
      mq.push_back(ird);
    end
    m_cnt = m_cnt + (fire ? 1 : 0) - (bacc ? 1 : 0);
    if (m_stall) begin
      if (bacc) begin m_stall = 0; m_starve = 0; end
    end else if (bv && !bacc) begin
      m_starve++;
      if (m_starve >= SL) m_stall = 1;
    end else m_starve = 0;
    #1;
    chk("rf_write", rf_write, m_write);
    if (m_write) begin
      chk("rf_in", rf_in, m_in);
      chk("rf_addrw", rf_addrw, m_addrw);
    end
    chk("stall_req", stall_req, m_stall);
  endtask

  task automatic idle(input logic [4:0] a1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, a1, 0);
  endtask

  initial begin
    bit bv, av, iv;
    logic [4:0] ba, aa, ird, a1, a2;
    rst_n = 0;
    a_valid = 0; a_addr = 0; a_data = 0; b_valid = 0; b_addr = 0; b_data = 0;
    issue_valid = 0; issue_rd = 0; addr1 = 0; addr2 = 0;
    model_reset();
    #12;
    chk("rst_rf_write", rf_write, 0);
    chk("rst_rf_in", rf_in, 0);
    chk("rst_rf_addrw", rf_addrw, 0);
    chk("rst_stall", stall_req, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // A write x5=42
    cyc(1, 5, 42, 0, 0, 0, 0, 0, 0, 0);
    chk("a_wr_write", rf_write, 1);
    chk("a_wr_addr", rf_addrw, 5);
    chk("a_wr_data", rf_in, 42);
`ifdef RF_WB_BYPASS_EN
    addr1 = 5; #1; chk("byp_x5_hit", byp1_hit, 1); chk("byp_x5_data", byp1_data, 42);
    addr1 = 0; #1; chk("byp_x0_hit", byp1_hit, 0);
`endif
    idle(0);

    // Issue rd10, hazard, B completes
    cyc(0, 0, 0, 0, 0, 0, 1, 10, 10, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 10, 0);
    chk("haz_rd10", haz1, 1);
    cyc(0, 0, 0, 1, 10, 99, 0, 0, 10, 0);
    chk("b_wr_data", rf_in, 99);
    chk("haz_clr", haz1, 0);

    // Starvation: B blocked 4 cycles by real A writes
    cyc(0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
    for (int i = 0; i < SL; i++) begin
      if (i == SL - 1) chk("stall_pre", stall_req, 0);
      cyc(1, 1, 32'(i), 1, 12, 77, 0, 0, 0, 0);
    end
    chk("stall_on", stall_req, 1);
    cyc(0, 0, 0, 1, 12, 77, 0, 0, 0, 0);
    chk("stall_off", stall_req, 0);

    // A to x0 concurrent with B to x7
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    cyc(1, 0, 55, 1, 7, 66, 0, 0, 0, 0);
    chk("x0a_b_write", rf_write, 1);
    chk("x0a_b_addr", rf_addrw, 7);
    cyc(1, 0, 55, 0, 0, 0, 0, 0, 0, 0);
    chk("x0a_only", rf_write, 0);

    // Outstanding limit
    cyc(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 3, 3, 4);
    chk("max_out_full", issue_ready, 0);
    cyc(0, 0, 0, 1, 3, 33, 0, 0, 0, 0);
    issue_rd = 5; #1;
    chk("max_out_free", issue_ready, 1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      bv = (mq.size() > 0) && ($urandom_range(1, 0) == 1);
      ba = (mq.size() > 0) ? mq[0] : 5'($urandom);
      av = m_stall ? ($urandom_range(3, 0) == 0) : ($urandom_range(2, 0) != 0);
      aa = ($urandom_range(5, 0) == 0) ? 5'd0 : 5'($urandom);
      iv = ($urandom_range(2, 0) == 0);
      if (mq.size() > 0 && $urandom_range(2, 0) == 0) ird = mq[mq.size() - 1];
      else if ($urandom_range(7, 0) == 0) ird = 5'd0;
      else ird = 5'($urandom);
      a1 = (mq.size() > 0 && $urandom_range(1, 0) == 1) ? mq[0] : 5'($urandom);
      a2 = 5'($urandom);
      cyc(av, aa, $urandom, bv, ba, $urandom, iv, ird, a1, a2);
    end

    // Asynchronous reset mid-operation
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    cyc(1, 6, 123, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_rf_write", rf_write, 0);
    chk("arst_rf_in", rf_in, 0);
    chk("arst_stall", stall_req, 0);
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    chk("arst_haz", haz1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
